rx_data_receive: RTL and testbench
==================================

Name: rx_data_receive

Overview:
- Receive-side character handler of the SpaceWire codec (ECSS-E-ST-50-12C), the counterpart of the transmit data/time-code selector.
- Consumes decoded characters from the RX deserializer and classifies them into NULL, FCT, N-chars (data/EOP/EEP) and time-codes.
- Writes N-chars to the host RX buffer, maintains the receive credit for FCT issuance, and flags escape/parity/credit errors to the link state machine.

Parameters:
- MAX_CREDIT, 56, maximum outstanding receive credit in N-chars (7 FCTs).
- FCT_STEP, 8, credit granted per FCT transmitted.

Ports:
- pclk_rx  in  1  receive clock.
- enable_rx  in  1  reset, asynchronous, active-low; low clears all state.
- rx_char_valid  in  1  one-cycle strobe: a decoded character is present.
- rx_char_ctrl  in  1  1 = control character, 0 = data character.
- rx_char_data  in  8  data byte; for control characters, [1:0] is the code: 00 FCT, 01 EOP, 10 EEP, 11 ESC.
- rx_parity_error  in  1  qualifies rx_char_valid: parity failed.
- fct_sent  in  1  pulse from TX: one FCT was transmitted.
- rx_buffer_full  in  1  host RX FIFO cannot accept a write.
- rx_buffer_write  out  1  one-cycle write strobe.
- rx_buffer_data  out  9  [8] = control flag; EOP = 9'h100, EEP = 9'h101, data = {1'b0, byte}.
- rx_got_null  out  1  pulse per NULL received.
- rx_got_fct  out  1  pulse per standalone FCT received.
- rx_got_nchar  out  1  pulse per N-char accepted.
- rx_null_seen  out  1  sticky: first NULL received.
- tick_out  out  1  pulse: valid time-code received.
- time_out  out  8  last received time-code.
- rx_credit  out  6  current receive credit.
- fct_allowed  out  1  rx_credit <= MAX_CREDIT - FCT_STEP.
- rx_error_esc  out  1  sticky escape error.
- rx_error_parity  out  1  sticky parity error.
- rx_error_credit  out  1  sticky credit error.

Behaviour:
- Reset: every output is 0 (time_out 8'h00, rx_credit 0); FSM goes to ST_WAIT_NULL.
- All outputs are registered. Every response appears in the cycle after the rx_char_valid edge that carries the triggering character.
- FSM states:
  - ST_WAIT_NULL: only the ESC->FCT pair is recognised. It sets rx_null_seen, pulses rx_got_null, then goes to ST_RUN. All other characters are ignored, and escape errors are not flagged here.
  - ST_RUN:
    - FCT: pulse rx_got_fct.
    - EOP or EEP: N-char.
    - Data character: N-char.
    - ESC: go to ST_ESC.
  - ST_ESC, on the next valid character:
    - FCT: NULL, pulse rx_got_null, go to ST_RUN.
    - Data character: time-code, go to ST_RUN.
    - ESC, EOP or EEP: set rx_error_esc, go to ST_ERROR.
  - ST_ERROR: all input is ignored until reset. Outputs hold; pulse outputs are 0.
- Parity: rx_parity_error with rx_char_valid, in any state except ST_ERROR, sets rx_error_parity and goes to ST_ERROR. The character is discarded.
- N-char acceptance:
  - Requires rx_credit > 0 and !rx_buffer_full.
  - Effect: rx_buffer_write = 1, rx_got_nchar = 1, rx_credit decrements by 1.
  - Otherwise: set rx_error_credit, drop the character, go to ST_ERROR.
- Credit update:
  - fct_sent adds FCT_STEP, saturating at MAX_CREDIT with no error.
  - fct_sent in the same cycle as an accepted N-char gives a net of +FCT_STEP-1.
  - fct_sent continues to update rx_credit in every state, including ST_WAIT_NULL and ST_ERROR.
- Time-code:
  - time_out <= rx_char_data on every time-code.
  - tick_out = 1 only when rx_char_data[5:0] == time_out[5:0]+1 (mod 64); the control bits [7:6] are not compared.
- rx_char_valid is never asserted on consecutive cycles by the deserializer. The block must still handle back-to-back strobes correctly.
- enable_rx falling mid-character: immediate asynchronous clear. A character in flight is lost, with no write.

Decomposition:
- Shared codec package holds:
  - control codes CTRL_FCT/EOP/EEP/ESC;
  - EOP/EEP buffer encodings 9'h100/9'h101;
  - RX FSM state encoding;
  - MAX_CREDIT and FCT_STEP defaults.
- One natural sub-module: rx_credit_counter (saturating add-8 / sub-1 counter with fct_allowed compare).

Test Plan:
- Reset, then data 0x55 before any NULL -> no write, rx_null_seen = 0. Then ESC, FCT -> rx_got_null pulse, rx_null_seen = 1.
- After NULL, fct_sent x2 (rx_credit = 16), send data 0xA5 then EOP -> writes 9'h0A5, 9'h100, rx_credit = 14, fct_allowed = 1.
- time_out = 0x05, receive ESC + 0x06 -> tick_out pulse, time_out = 0x06. Then ESC + 0x09 -> time_out = 0x09, no tick.
- rx_credit = 0, data 0x11 received -> no write, rx_error_credit = 1, subsequent FCT produces no rx_got_fct.
- ESC followed by EOP in ST_RUN -> rx_error_esc = 1, no write. Character with rx_parity_error (fresh reset, after NULL) -> rx_error_parity = 1.
- fct_sent x8 -> rx_credit saturates at 56, fct_allowed = 0. fct_sent coincident with accepted N-char at credit 10 -> 17.

Source files
------------

// File: rtl/rx_data_receive_pkg.sv
// Shared codec definitions for the SpaceWire receive path: control codes,
// host buffer encodings, RX FSM state encoding and credit defaults.
package rx_data_receive_pkg;

    localparam int MAX_CREDIT_DEF = 56;
    localparam int FCT_STEP_DEF   = 8;

    // Control character codes carried in rx_char_data[1:0]
    localparam logic [1:0] CTRL_FCT = 2'b00;
    localparam logic [1:0] CTRL_EOP = 2'b01;
    localparam logic [1:0] CTRL_EEP = 2'b10;
    localparam logic [1:0] CTRL_ESC = 2'b11;

    // Host RX buffer encodings for end-of-packet markers
    localparam logic [8:0] BUF_EOP = 9'h100;
    localparam logic [8:0] BUF_EEP = 9'h101;

    // RX FSM states. ST_WAIT_ESC is the half-way point of the first NULL:
    // an ESC has arrived while still waiting for the link to show a NULL.
    typedef enum logic [2:0] {
        ST_WAIT_NULL = 3'd0,
        ST_WAIT_ESC  = 3'd1,
        ST_RUN       = 3'd2,
        ST_ESC       = 3'd3,
        ST_ERROR     = 3'd4
    } rx_state_t;

    // Map an N-char (data byte, EOP or EEP) onto the 9-bit buffer word
    function automatic logic [8:0] nchar_encode(input logic ctrl, input logic [7:0] data);
        logic [8:0] word;
        if (!ctrl) begin
            word = {1'b0, data};
        end else if (data[1:0] == CTRL_EOP) begin
            word = BUF_EOP;
        end else begin
            word = BUF_EEP;
        end
        return word;
    endfunction

endpackage

// File: rtl/rx_data_receive_credit.sv
// Receive credit counter: +FCT_STEP per transmitted FCT, -1 per accepted
// N-char, saturating at MAX_CREDIT. fct_allowed tells TX that one more
// FCT fits without exceeding MAX_CREDIT.
module rx_credit_counter
    import rx_data_receive_pkg::*;
#(
    parameter int MAX_CREDIT = MAX_CREDIT_DEF,
    parameter int FCT_STEP   = FCT_STEP_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fct_sent,
    input  logic       consume,
    output logic [5:0] credit,
    output logic       fct_allowed
);

    logic [6:0] sum;
    logic [5:0] credit_d;

    // Next credit; one extra bit catches the overshoot above MAX_CREDIT.
    // consume is only raised by the caller when credit is non-zero.
    always_comb begin
        sum = {1'b0, credit};
        if (fct_sent) begin
            sum = sum + 7'(FCT_STEP);
        end
        if (consume) begin
            sum = sum - 7'd1;
        end
        if (sum > 7'(MAX_CREDIT)) begin
            credit_d = 6'(MAX_CREDIT);
        end else begin
            credit_d = sum[5:0];
        end
    end

    // Credit and its FCT threshold are registered together so they never disagree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit      <= 6'd0;
            fct_allowed <= 1'b0;
        end else begin
            credit      <= credit_d;
            fct_allowed <= (credit_d <= 6'(MAX_CREDIT - FCT_STEP));
        end
    end

endmodule

// File: rtl/rx_data_receive.sv
// SpaceWire receive character handler. Classifies decoded characters into
// NULL, FCT, N-chars and time-codes, writes N-chars to the host buffer,
// tracks receive credit and raises sticky link errors.
//
// Handshake: rx_char_valid is a single-cycle strobe with no back-pressure;
// every character is consumed on the edge that samples it. rx_buffer_write
// is a single-cycle strobe; the host guarantees space whenever
// rx_buffer_full is low, otherwise the character is a credit error.
module rx_data_receive
    import rx_data_receive_pkg::*;
#(
    parameter int MAX_CREDIT = MAX_CREDIT_DEF,
    parameter int FCT_STEP   = FCT_STEP_DEF
) (
    input  logic       pclk_rx,
    input  logic       enable_rx,
    input  logic       rx_char_valid,
    input  logic       rx_char_ctrl,
    input  logic [7:0] rx_char_data,
    input  logic       rx_parity_error,
    input  logic       fct_sent,
    input  logic       rx_buffer_full,
    output logic       rx_buffer_write,
    output logic [8:0] rx_buffer_data,
    output logic       rx_got_null,
    output logic       rx_got_fct,
    output logic       rx_got_nchar,
    output logic       rx_null_seen,
    output logic       tick_out,
    output logic [7:0] time_out,
    output logic [5:0] rx_credit,
    output logic       fct_allowed,
    output logic       rx_error_esc,
    output logic       rx_error_parity,
    output logic       rx_error_credit,
    output logic [2:0] rx_state_dbg
);

    rx_state_t state_q;
    rx_state_t state_d;

    logic       is_fct;
    logic       is_esc;
    logic       nchar_req;
    logic       nchar_ok;
    logic       live_char;

    logic       write_d;
    logic [8:0] data_d;
    logic       got_null_d;
    logic       got_fct_d;
    logic       got_nchar_d;
    logic       null_seen_d;
    logic       tick_d;
    logic [7:0] time_d;
    logic       err_esc_d;
    logic       err_parity_d;
    logic       err_credit_d;

    // Character classification shared by next-state and output logic
    always_comb begin
        live_char = rx_char_valid && (state_q != ST_ERROR) && !rx_parity_error;
        is_fct    = rx_char_ctrl && (rx_char_data[1:0] == CTRL_FCT);
        is_esc    = rx_char_ctrl && (rx_char_data[1:0] == CTRL_ESC);
        nchar_req = live_char && (state_q == ST_RUN) && !is_fct && !is_esc;
        nchar_ok  = nchar_req && (rx_credit != 6'd0) && !rx_buffer_full;
    end

    // State register
    always_ff @(posedge pclk_rx or negedge enable_rx) begin
        if (!enable_rx) begin
            state_q <= ST_WAIT_NULL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (rx_char_valid && (state_q != ST_ERROR)) begin
            if (rx_parity_error) begin
                state_d = ST_ERROR;
            end else begin
                case (state_q)
                    ST_WAIT_NULL: begin
                        if (is_esc) state_d = ST_WAIT_ESC;
                    end
                    ST_WAIT_ESC: begin
                        if (is_fct)      state_d = ST_RUN;
                        else if (is_esc) state_d = ST_WAIT_ESC;
                        else             state_d = ST_WAIT_NULL;
                    end
                    ST_RUN: begin
                        if (is_esc)                    state_d = ST_ESC;
                        else if (nchar_req && !nchar_ok) state_d = ST_ERROR;
                    end
                    ST_ESC: begin
                        if (is_fct || !rx_char_ctrl) state_d = ST_RUN;
                        else                         state_d = ST_ERROR;
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        write_d      = 1'b0;
        data_d       = rx_buffer_data;
        got_null_d   = 1'b0;
        got_fct_d    = 1'b0;
        got_nchar_d  = 1'b0;
        tick_d       = 1'b0;
        time_d       = time_out;
        null_seen_d  = rx_null_seen;
        err_esc_d    = rx_error_esc;
        err_parity_d = rx_error_parity;
        err_credit_d = rx_error_credit;
        if (rx_char_valid && (state_q != ST_ERROR)) begin
            if (rx_parity_error) begin
                err_parity_d = 1'b1;
            end else begin
                case (state_q)
                    ST_WAIT_ESC: begin
                        if (is_fct) begin
                            got_null_d  = 1'b1;
                            null_seen_d = 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (is_fct) begin
                            got_fct_d = 1'b1;
                        end else if (nchar_ok) begin
                            write_d     = 1'b1;
                            got_nchar_d = 1'b1;
                            data_d      = nchar_encode(rx_char_ctrl, rx_char_data);
                        end else if (nchar_req) begin
                            err_credit_d = 1'b1;
                        end
                    end
                    ST_ESC: begin
                        if (is_fct) begin
                            got_null_d  = 1'b1;
                            null_seen_d = 1'b1;
                        end else if (!rx_char_ctrl) begin
                            // Only the 6-bit counter must advance by one; control bits are free
                            time_d = rx_char_data;
                            tick_d = (rx_char_data[5:0] == time_out[5:0] + 6'd1);
                        end else begin
                            err_esc_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output registers; buffer data holds the last written word
    always_ff @(posedge pclk_rx or negedge enable_rx) begin
        if (!enable_rx) begin
            rx_buffer_write <= 1'b0;
            rx_buffer_data  <= 9'h000;
            rx_got_null     <= 1'b0;
            rx_got_fct      <= 1'b0;
            rx_got_nchar    <= 1'b0;
            rx_null_seen    <= 1'b0;
            tick_out        <= 1'b0;
            time_out        <= 8'h00;
            rx_error_esc    <= 1'b0;
            rx_error_parity <= 1'b0;
            rx_error_credit <= 1'b0;
        end else begin
            rx_buffer_write <= write_d;
            rx_buffer_data  <= data_d;
            rx_got_null     <= got_null_d;
            rx_got_fct      <= got_fct_d;
            rx_got_nchar    <= got_nchar_d;
            rx_null_seen    <= null_seen_d;
            tick_out        <= tick_d;
            time_out        <= time_d;
            rx_error_esc    <= err_esc_d;
            rx_error_parity <= err_parity_d;
            rx_error_credit <= err_credit_d;
        end
    end

    assign rx_state_dbg = state_q;

    rx_credit_counter #(
        .MAX_CREDIT (MAX_CREDIT),
        .FCT_STEP   (FCT_STEP)
    ) u_credit (
        .clk         (pclk_rx),
        .rst_n       (enable_rx),
        .fct_sent    (fct_sent),
        .consume     (nchar_ok),
        .credit      (rx_credit),
        .fct_allowed (fct_allowed)
    );

endmodule

// File: tb/tb_rx_data_receive.sv
// Bench for rx_data_receive: table of directed vectors, hand sequences for
// multi-cycle corners, and randomized traffic checked against a flag-based
// reference model of the receive rules.
module tb_rx_data_receive;

    logic       pclk_rx;
    logic       enable_rx;
    logic       rx_char_valid;
    logic       rx_char_ctrl;
    logic [7:0] rx_char_data;
    logic       rx_parity_error;
    logic       fct_sent;
    logic       rx_buffer_full;
    logic       rx_buffer_write;
    logic [8:0] rx_buffer_data;
    logic       rx_got_null;
    logic       rx_got_fct;
    logic       rx_got_nchar;
    logic       rx_null_seen;
    logic       tick_out;
    logic [7:0] time_out;
    logic [5:0] rx_credit;
    logic       fct_allowed;
    logic       rx_error_esc;
    logic       rx_error_parity;
    logic       rx_error_credit;
    logic [2:0] rx_state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    rx_data_receive dut (
        .pclk_rx         (pclk_rx),
        .enable_rx       (enable_rx),
        .rx_char_valid   (rx_char_valid),
        .rx_char_ctrl    (rx_char_ctrl),
        .rx_char_data    (rx_char_data),
        .rx_parity_error (rx_parity_error),
        .fct_sent        (fct_sent),
        .rx_buffer_full  (rx_buffer_full),
        .rx_buffer_write (rx_buffer_write),
        .rx_buffer_data  (rx_buffer_data),
        .rx_got_null     (rx_got_null),
        .rx_got_fct      (rx_got_fct),
        .rx_got_nchar    (rx_got_nchar),
        .rx_null_seen    (rx_null_seen),
        .tick_out        (tick_out),
        .time_out        (time_out),
        .rx_credit       (rx_credit),
        .fct_allowed     (fct_allowed),
        .rx_error_esc    (rx_error_esc),
        .rx_error_parity (rx_error_parity),
        .rx_error_credit (rx_error_credit),
        .rx_state_dbg    (rx_state_dbg)
    );

    // ---------------- clock ----------------
    initial pclk_rx = 1'b0;
    always #5 pclk_rx = ~pclk_rx;

    // ---------------- reference model ----------------
    bit         m_seen, m_dead, m_esc;
    int         m_credit;
    logic [7:0] m_time;
    bit         m_eesc, m_epar, m_ecred;
    bit         m_write, m_null, m_fct, m_nchar, m_tick;
    logic [8:0] m_bdata;

    task automatic model_reset();
        m_seen = 0; m_dead = 0; m_esc = 0; m_credit = 0; m_time = 8'h00;
        m_eesc = 0; m_epar = 0; m_ecred = 0;
        m_write = 0; m_null = 0; m_fct = 0; m_nchar = 0; m_tick = 0;
        m_bdata = 9'h000;
    endtask

    task automatic model_step(input bit v, input bit c, input logic [7:0] d,
                              input bit p, input bit f, input bit full);
        int code;
        int acc;
        code = int'(d[1:0]);
        acc  = 0;
        m_write = 0; m_null = 0; m_fct = 0; m_nchar = 0; m_tick = 0;
        if (v && !m_dead) begin
            if (p) begin
                m_epar = 1; m_dead = 1;
            end else if (!m_seen) begin
                if (m_esc && c && code == 0) begin
                    m_seen = 1; m_null = 1; m_esc = 0;
                end else begin
                    m_esc = c && code == 3;
                end
            end else if (m_esc) begin
                m_esc = 0;
                if (!c) begin
                    m_tick = (int'(d) % 64) == ((int'(m_time) + 1) % 64);
                    m_time = d;
                end else if (code == 0) begin
                    m_null = 1;
                end else begin
                    m_eesc = 1; m_dead = 1;
                end
            end else if (c && code == 0) begin
                m_fct = 1;
            end else if (c && code == 3) begin
                m_esc = 1;
            end else if (m_credit > 0 && !full) begin
                m_write = 1; m_nchar = 1; acc = 1;
                if (!c)            m_bdata = {1'b0, d};
                else if (code == 1) m_bdata = 9'h100;
                else               m_bdata = 9'h101;
            end else begin
                m_ecred = 1; m_dead = 1;
            end
        end
        m_credit = m_credit + (f ? 8 : 0) - acc;
        if (m_credit > 56) m_credit = 56;
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {8'h00, rx_buffer_write, rx_got_null, rx_got_fct, rx_got_nchar,
                rx_null_seen, tick_out, time_out, rx_credit, fct_allowed,
                rx_error_esc, rx_error_parity, rx_error_credit};
    endfunction

    function automatic logic [31:0] model_vec();
        return {8'h00, m_write, m_null, m_fct, m_nchar, m_seen, m_tick, m_time,
                6'(m_credit), (m_credit <= 48), m_eesc, m_epar, m_ecred};
    endfunction

    task automatic compare_model(input string name);
        exp_q.push_back(model_vec());
        chk(name, dut_vec(), exp_q.pop_front());
        if (m_write) chk({name, "_data"}, 32'(rx_buffer_data), 32'(m_bdata));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit v, input bit c, input logic [7:0] d,
                        input bit p, input bit f, input bit full);
        rx_char_valid   = v;
        rx_char_ctrl    = c;
        rx_char_data    = d;
        rx_parity_error = p;
        fct_sent        = f;
        rx_buffer_full  = full;
        model_step(v, c, d, p, f, full);
        @(posedge pclk_rx);
        #1;
        compare_model("model");
    endtask

    task automatic send(input bit c, input logic [7:0] d);
        step(1, c, d, 0, 0, 0);
    endtask

    task automatic idle_fct();
        step(0, 0, 8'h00, 0, 1, 0);
    endtask

    task automatic do_reset();
        enable_rx       = 1'b0;
        rx_char_valid   = 1'b0;
        rx_char_ctrl    = 1'b0;
        rx_char_data    = 8'h00;
        rx_parity_error = 1'b0;
        fct_sent        = 1'b0;
        rx_buffer_full  = 1'b0;
        #1;
        chk("reset_outputs", {dut_vec()[31:8], 1'b0, dut_vec()[6:0]}, 32'h0);
        chk("reset_bdata", 32'(rx_buffer_data), 32'h0);
        model_reset();
        @(negedge pclk_rx);
        enable_rx = 1'b1;
        @(posedge pclk_rx);
        #1;
    endtask

    task automatic get_null();
        send(1, 8'h03);
        send(1, 8'h00);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         v, c, p, f, full;
        logic [7:0] d;
        bit         e_write;
        logic [8:0] e_bdata;
        logic [3:0] e_pulse;  // {null, fct, nchar, tick}
        bit         e_seen;
        logic [7:0] e_time;
        logic [5:0] e_credit;
        logic [2:0] e_err;    // {esc, parity, credit}
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input bit v, input bit c, input logic [7:0] d, input bit f,
                           input bit full, input bit e_write, input logic [8:0] e_bdata,
                           input logic [3:0] e_pulse, input bit e_seen,
                           input logic [7:0] e_time, input logic [5:0] e_credit,
                           input logic [2:0] e_err);
        vec_t r;
        r.v = v; r.c = c; r.d = d; r.p = 0; r.f = f; r.full = full;
        r.e_write = e_write; r.e_bdata = e_bdata; r.e_pulse = e_pulse;
        r.e_seen = e_seen; r.e_time = e_time; r.e_credit = e_credit; r.e_err = e_err;
        tbl.push_back(r);
    endtask

    initial begin
        // v c d     f full wr bdata    pulses   seen time   credit err
        add_vec(1, 0, 8'h55, 0, 0, 0, 9'h000, 4'b0000, 0, 8'h00, 6'd0,  3'b000);
        add_vec(1, 1, 8'h03, 0, 0, 0, 9'h000, 4'b0000, 0, 8'h00, 6'd0,  3'b000);
        add_vec(1, 1, 8'h00, 0, 0, 0, 9'h000, 4'b1000, 1, 8'h00, 6'd0,  3'b000);
        add_vec(0, 0, 8'h00, 1, 0, 0, 9'h000, 4'b0000, 1, 8'h00, 6'd8,  3'b000);
        add_vec(0, 0, 8'h00, 1, 0, 0, 9'h000, 4'b0000, 1, 8'h00, 6'd16, 3'b000);
        add_vec(1, 0, 8'hA5, 0, 0, 1, 9'h0A5, 4'b0010, 1, 8'h00, 6'd15, 3'b000);
        add_vec(1, 1, 8'h01, 0, 0, 1, 9'h100, 4'b0010, 1, 8'h00, 6'd14, 3'b000);
        add_vec(1, 1, 8'h03, 0, 0, 0, 9'h000, 4'b0000, 1, 8'h00, 6'd14, 3'b000);
        add_vec(1, 0, 8'h05, 0, 0, 0, 9'h000, 4'b0000, 1, 8'h05, 6'd14, 3'b000);
        add_vec(1, 1, 8'h03, 0, 0, 0, 9'h000, 4'b0000, 1, 8'h05, 6'd14, 3'b000);
        add_vec(1, 0, 8'h06, 0, 0, 0, 9'h000, 4'b0001, 1, 8'h06, 6'd14, 3'b000);
        add_vec(1, 1, 8'h03, 0, 0, 0, 9'h000, 4'b0000, 1, 8'h06, 6'd14, 3'b000);
        add_vec(1, 0, 8'h09, 0, 0, 0, 9'h000, 4'b0000, 1, 8'h09, 6'd14, 3'b000);
        add_vec(1, 1, 8'h00, 0, 0, 0, 9'h000, 4'b0100, 1, 8'h09, 6'd14, 3'b000);
        add_vec(1, 1, 8'h02, 0, 0, 1, 9'h101, 4'b0010, 1, 8'h09, 6'd13, 3'b000);
        add_vec(1, 1, 8'h03, 0, 0, 0, 9'h000, 4'b0000, 1, 8'h09, 6'd13, 3'b000);
        add_vec(1, 0, 8'hCA, 0, 0, 0, 9'h000, 4'b0001, 1, 8'hCA, 6'd13, 3'b000);
        add_vec(1, 1, 8'hF8, 0, 0, 0, 9'h000, 4'b0100, 1, 8'hCA, 6'd13, 3'b000);
        add_vec(1, 0, 8'h00, 0, 1, 0, 9'h000, 4'b0000, 1, 8'hCA, 6'd13, 3'b001);
        add_vec(1, 1, 8'h00, 0, 0, 0, 9'h000, 4'b0000, 1, 8'hCA, 6'd13, 3'b001);
        add_vec(0, 0, 8'h00, 1, 0, 0, 9'h000, 4'b0000, 1, 8'hCA, 6'd21, 3'b001);
    end

    // ---------------- test sequence ----------------
    initial begin
        do_reset();

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].c, tbl[i].d, tbl[i].p, tbl[i].f, tbl[i].full);
            chk($sformatf("tbl%0d_write", i), 32'(rx_buffer_write), 32'(tbl[i].e_write));
            if (tbl[i].e_write)
                chk($sformatf("tbl%0d_bdata", i), 32'(rx_buffer_data), 32'(tbl[i].e_bdata));
            chk($sformatf("tbl%0d_pulse", i),
                32'({rx_got_null, rx_got_fct, rx_got_nchar, tick_out}), 32'(tbl[i].e_pulse));
            chk($sformatf("tbl%0d_state", i), 32'({rx_null_seen, time_out, rx_credit}),
                32'({tbl[i].e_seen, tbl[i].e_time, tbl[i].e_credit}));
            chk($sformatf("tbl%0d_err", i),
                32'({rx_error_esc, rx_error_parity, rx_error_credit}), 32'(tbl[i].e_err));
        end

        // Credit saturation and fct_allowed boundary (works before any NULL)
        do_reset();
        for (int i = 0; i < 6; i++) idle_fct();
        chk("credit48", 32'(rx_credit), 32'd48);
        chk("allowed48", 32'(fct_allowed), 32'd1);
        idle_fct();
        chk("allowed56", 32'(fct_allowed), 32'd0);
        idle_fct();
        chk("credit_sat", 32'(rx_credit), 32'd56);
        chk("allowed_sat", 32'(fct_allowed), 32'd0);

        // Coincident fct_sent and accepted N-char at credit 10
        do_reset();
        get_null();
        idle_fct(); idle_fct();
        for (int i = 0; i < 6; i++) send(0, 8'(i));
        chk("credit10", 32'(rx_credit), 32'd10);
        step(1, 0, 8'h3C, 0, 1, 0);
        chk("coinc_credit", 32'(rx_credit), 32'd17);
        chk("coinc_write", 32'({rx_buffer_write, rx_buffer_data}), 32'({1'b1, 9'h03C}));

        // Credit error at zero credit, then FCT ignored
        do_reset();
        get_null();
        send(0, 8'h11);
        chk("cred0_write", 32'(rx_buffer_write), 32'd0);
        chk("cred0_err", 32'(rx_error_credit), 32'd1);
        send(1, 8'h00);
        chk("cred0_fct_ignored", 32'(rx_got_fct), 32'd0);

        // Escape error: ESC then EOP
        do_reset();
        get_null();
        idle_fct();
        send(1, 8'h03);
        send(1, 8'h01);
        chk("esc_err", 32'(rx_error_esc), 32'd1);
        chk("esc_nowrite", 32'(rx_buffer_write), 32'd0);

        // Parity error discards the character
        do_reset();
        get_null();
        idle_fct();
        step(1, 0, 8'h77, 1, 0, 0);
        chk("par_err", 32'(rx_error_parity), 32'd1);
        chk("par_nowrite", 32'(rx_buffer_write), 32'd0);
        send(0, 8'h78);
        chk("par_dead", 32'(rx_buffer_write), 32'd0);

        // Back-to-back strobes at credit 1: first accepted, second is a credit error
        do_reset();
        get_null();
        idle_fct();
        for (int i = 0; i < 7; i++) send(0, 8'h40);
        send(0, 8'h41);
        chk("b2b_first", 32'({rx_buffer_write, rx_credit}), 32'({1'b1, 6'd0}));
        send(0, 8'h42);
        chk("b2b_second", 32'({rx_buffer_write, rx_error_credit}), 32'({1'b0, 1'b1}));

        // Asynchronous clear with a character in flight
        do_reset();
        get_null();
        idle_fct();
        rx_char_valid = 1'b1; rx_char_ctrl = 1'b0; rx_char_data = 8'h99;
        #2;
        enable_rx = 1'b0;
        #1;
        chk("async_clear", {dut_vec()[31:8], 1'b0, dut_vec()[6:0]}, 32'h0);
        @(posedge pclk_rx);
        #1;
        chk("async_nowrite", 32'(rx_buffer_write), 32'd0);
        rx_char_valid = 1'b0;
        model_reset();
        @(negedge pclk_rx);
        enable_rx = 1'b1;
        @(posedge pclk_rx);
        #1;

        // Randomized traffic against the model
        for (int run = 0; run < 60; run++) begin
            do_reset();
            if ($urandom_range(0, 3) != 0) get_null();
            for (int cyc = 0; cyc < 80; cyc++) begin
                bit         v, c, p, f, full;
                logic [7:0] d;
                v    = ($urandom_range(0, 99) < 55);
                c    = ($urandom_range(0, 99) < 25);
                d    = 8'($urandom);
                if (!c && $urandom_range(0, 3) == 0) d[5:0] = m_time[5:0] + 6'd1;
                p    = ($urandom_range(0, 199) == 0);
                f    = ($urandom_range(0, 99) < 15);
                full = ($urandom_range(0, 99) < 5);
                step(v, c, d, p, f, full);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
